// File: rtl/pip_adder_arbiter.sv
// pip_adder_arbiter: round-robin sharing of one fixed-latency pipelined adder between two requesters
module pip_adder_arbiter #(
  parameter int WIDTH   = 16,
  parameter int LAT     = 20,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout,
  output logic             busy
);
  localparam int CW = 4;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
  logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic [WIDTH-1:0] rsp0_sum_q, rsp0_sum_d, rsp1_sum_q, rsp1_sum_d;
  logic add_cin_q, add_cin_d, rr_q, rr_d;
  logic rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic rsp0_cout_q, rsp0_cout_d, rsp1_cout_q, rsp1_cout_d;
  logic [LAT:0] tv_q, tv_d, ti_q, ti_d;
  logic [CW-1:0] out0_q, out0_d, out1_q, out1_d;
  logic elig0, elig1, grant0, grant1;
  // tag stage k is valid in cycle t+1+k, so stage LAT lines up with add_s
  always_comb begin
    elig0 = req0_valid && (out0_q < MAX_C);
    elig1 = req1_valid && (out1_q < MAX_C);
    grant0 = elig0 && (!elig1 || !rr_q);
    grant1 = elig1 && (!elig0 || rr_q);
    rr_d = grant0 ? 1'b1 : grant1 ? 1'b0 : rr_q;
    add_a_d = grant0 ? req0_a : grant1 ? req1_a : '0;
    add_b_d = grant0 ? req0_b : grant1 ? req1_b : '0;
    add_cin_d = grant0 ? req0_cin : grant1 ? req1_cin : 1'b0;
    tv_d = {tv_q[LAT-1:0], grant0 | grant1};
    ti_d = {ti_q[LAT-1:0], grant1};
    rsp0_valid_d = tv_q[LAT] && !ti_q[LAT];
    rsp1_valid_d = tv_q[LAT] && ti_q[LAT];
    rsp0_sum_d = rsp0_valid_d ? add_s : rsp0_sum_q;
    rsp0_cout_d = rsp0_valid_d ? add_cout : rsp0_cout_q;
    rsp1_sum_d = rsp1_valid_d ? add_s : rsp1_sum_q;
    rsp1_cout_d = rsp1_valid_d ? add_cout : rsp1_cout_q;
    out0_d = out0_q + CW'(grant0) - CW'(rsp0_valid_q);
    out1_d = out1_q + CW'(grant1) - CW'(rsp1_valid_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a_q <= '0;
      add_b_q <= '0;
      add_cin_q <= 1'b0;
      rr_q <= 1'b0;
      tv_q <= '0;
      ti_q <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_sum_q <= '0;
      rsp1_sum_q <= '0;
      rsp0_cout_q <= 1'b0;
      rsp1_cout_q <= 1'b0;
      out0_q <= '0;
      out1_q <= '0;
    end else begin
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      add_cin_q <= add_cin_d;
      rr_q <= rr_d;
      tv_q <= tv_d;
      ti_q <= ti_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_sum_q <= rsp0_sum_d;
      rsp1_sum_q <= rsp1_sum_d;
      rsp0_cout_q <= rsp0_cout_d;
      rsp1_cout_q <= rsp1_cout_d;
      out0_q <= out0_d;
      out1_q <= out1_d;
    end
  end
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign add_a = add_a_q;
  assign add_b = add_b_q;
  assign add_cin = add_cin_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_sum = rsp0_sum_q;
  assign rsp0_cout = rsp0_cout_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_sum = rsp1_sum_q;
  assign rsp1_cout = rsp1_cout_q;
  assign busy = (|tv_q) | rsp0_valid_q | rsp1_valid_q;
endmodule

// File: tb/tb_pip_adder_arbiter.sv
// tb_pip_adder_arbiter: directed checks of arbitration, latency, throttling and reset using a modelled adder
module tb_pip_adder_arbiter;
  localparam int W = 16;
  localparam int LAT = 20;
  typedef struct {int cyc; logic [W-1:0] s; logic c;} rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req0_ready, req0_cin = 1'b0;
  logic req1_valid = 1'b0, req1_ready, req1_cin = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [W-1:0] add_a, add_b, add_s, rsp0_sum, rsp1_sum;
  logic add_cin, add_cout, rsp0_valid, rsp0_cout, rsp1_valid, rsp1_cout, busy;
  logic [W:0] pipe [LAT];
  rsp_t q0[$], q1[$];
  int cyc = 0, checks = 0, errors = 0, t_now = 0, tt = 0;
  pip_adder_arbiter #(.WIDTH(W), .LAT(LAT), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .rsp0_valid(rsp0_valid), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_s = pipe[LAT-1][W-1:0];
  assign add_cout = pipe[LAT-1][W];
  always @(negedge clk) begin
    if (rsp0_valid) q0.push_back('{cyc, rsp0_sum, rsp0_cout});
    if (rsp1_valid) q1.push_back('{cyc, rsp1_sum, rsp1_cout});
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v0, input logic [W-1:0] a0, b0, input logic c0,
                      input logic v1, input logic [W-1:0] a1, b1, input logic c1,
                      input logic e0, e1, input string tag);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    @(negedge clk);
    t_now = cyc;
    chk({tag, ".ready0"}, 32'(req0_ready), 32'(e0));
    chk({tag, ".ready1"}, 32'(req1_ready), 32'(e1));
    @(posedge clk); #1;
  endtask
  task automatic quiet();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    quiet();
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_rsp(input string tag, input rsp_t r, input int c, input logic [W-1:0] s, input logic co);
    chk({tag, ".cyc"}, r.cyc, c);
    chk({tag, ".sum"}, 32'(r.s), 32'(s));
    chk({tag, ".cout"}, 32'(r.c), 32'(co));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.rsp0_valid", 32'(rsp0_valid), 0);
    chk("rst.rsp1_valid", 32'(rsp1_valid), 0);
    chk("rst.add_a", 32'(add_a), 0);
    chk("rst.rsp0_sum", 32'(rsp0_sum), 0);
    @(posedge clk); #1;
    step(1, 16'h6F77, 16'h7178, 0, 0, 0, 0, 0, 1, 0, "t1");
    tt = t_now;
    quiet();
    @(negedge clk);
    chk("t1.add_a", 32'(add_a), 32'h6F77);
    chk("t1.add_b", 32'(add_b), 32'h7178);
    chk("t1.busy", 32'(busy), 1);
    idle(26);
    chk("t1.n0", q0.size(), 1);
    chk("t1.n1", q1.size(), 0);
    if (q0.size() > 0) chk_rsp("t1.rsp0", q0[0], tt + 22, 16'hE0EF, 0);
    chk("t1.hold", 32'(rsp0_sum), 32'hE0EF);
    chk("t1.idle_busy", 32'(busy), 0);
    q0.delete(); q1.delete();
    step(1, 16'h0001, 16'h0003, 1, 1, 16'h3000, 16'hF000, 0, 0, 1, "t2a");
    tt = t_now;
    step(1, 16'h0001, 16'h0003, 1, 0, 0, 0, 0, 1, 0, "t2b");
    idle(26);
    chk("t2.n0", q0.size(), 1);
    chk("t2.n1", q1.size(), 1);
    if (q1.size() > 0) chk_rsp("t2.rsp1", q1[0], tt + 22, 16'h2000, 1);
    if (q0.size() > 0) chk_rsp("t2.rsp0", q0[0], tt + 23, 16'h0005, 0);
    q0.delete(); q1.delete();
    for (int k = 0; k < 8; k++) begin
      step(1, 16'(16'h1000 + k), 16'h2000, 0, 1, 16'(16'hF000 + k), 16'h1000, 1, k[0], !k[0], "t3");
      if (k == 0) tt = t_now;
    end
    idle(32);
    chk("t3.n0", q0.size(), 4);
    chk("t3.n1", q1.size(), 4);
    for (int j = 0; j < 4 && j < q0.size() && j < q1.size(); j++) begin
      chk_rsp("t3.rsp1", q1[j], tt + 2*j + 22, 16'(1 + 2*j), 1);
      chk_rsp("t3.rsp0", q0[j], tt + 2*j + 23, 16'(16'h3001 + 2*j), 0);
    end
    q0.delete(); q1.delete();
    for (int k = 0; k < 30; k++)
      step(1, 16'(k), 16'h0000, 0, 0, 0, 0, 0, (k < 4) || (k >= 23 && k < 27), 0, "t4");
    idle(50);
    chk("t4.n0", q0.size(), 8);
    chk("t4.n1", q1.size(), 0);
    for (int k = 0; k < 3; k++) step(1, 16'h0F0F, 16'h0101, 0, 0, 0, 0, 0, 1, 0, "t5");
    quiet();
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    q0.delete(); q1.delete();
    @(negedge clk);
    chk("t5.busy", 32'(busy), 0);
    @(posedge clk); #1;
    step(0, 0, 0, 0, 1, 16'hAAAA, 16'h5555, 1, 0, 1, "t6a");
    tt = t_now;
    step(1, 16'h1234, 16'h1111, 0, 1, 16'hAAAA, 16'h5555, 1, 1, 0, "t6b");
    idle(40);
    chk("t5.n0", q0.size(), 1);
    chk("t6.n1", q1.size(), 1);
    if (q1.size() > 0) chk_rsp("t6.rsp1", q1[0], tt + 22, 16'h0000, 1);
    if (q0.size() > 0) chk_rsp("t5.rsp0", q0[0], tt + 23, 16'h2345, 0);
    chk("t5.end_busy", 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
